pipe_sequencer: RTL and testbench
=================================

// Module: pipe_sequencer
// PURPOSE
//  Two-stage fetch/execute sequencer for the 4-bit CPU datapath. Holds PC and instruction register,
//  fetches 8-bit instructions from program ROM, and presents the executing instruction on D_BUS.
//  Resolves JMP/JNC/HLT itself, using the datapath's registered carry flag, and flushes on taken jumps.
//  The ALU decodes every non-control opcode from D_BUS[7:4].
// PARAMETERS
//  OP_JMP   4'hF   opcode: unconditional jump to D_BUS[3:0]
//  OP_JNC   4'hE   opcode: jump to D_BUS[3:0] when cflag==0
//  OP_HLT   4'hD   opcode: stop sequencing until reset
//  OP_CALL  4'hC   opcode: call D_BUS[3:0] (SUBROUTINE_EN only)
//  OP_RET   4'hB   opcode: return (SUBROUTINE_EN only)
//  BUBBLE   8'h00  encoding driven on D_BUS when no valid instruction; must be side-effect free in ALU decode
// PORTS
//  clock      in   1  single clock, all state on posedge
//  reset      in   1  synchronous, active-high
//  run        in   1  level; leaves IDLE when high
//  hold       in   1  level; freezes PC/IR/state while high
//  rom_data   in   8  instruction at rom_addr, combinational ROM
//  cflag      in   1  registered carry flag from datapath
//  rom_addr   out  4  fetch address (= PC)
//  D_BUS      out  8  executing instruction or BUBBLE
//  halted     out  1  high in HALT state
//  stack_err  out  1  sticky call-stack fault (0 when SUBROUTINE_EN undefined)
// BEHAVIOUR
//  - Reset (sync, active-high): PC=0, ir_valid=0, state=IDLE, D_BUS=BUBBLE, halted=0, stack_err=0.
//  - States: IDLE -> RUN on run=1; RUN -> HALT when HLT executes; HALT exits only via reset. run ignored outside IDLE.
//  - RUN, hold=0, each cycle: IR<=rom_data, ir_valid<=1, PC<=PC+1 (4-bit wrap, 15->0).
//  - D_BUS = (state==RUN && ir_valid && !hold) ? IR : BUBBLE.
//  - Latency: run asserted at cycle N -> addr 0 fetched in N+1 -> instruction 0 on D_BUS in N+2.
//  - Taken JMP/JNC in execute: PC<=IR[3:0], ir_valid<=0 (flush fetched word); next D_BUS=BUBBLE,
//    target on D_BUS one cycle later. Taken-jump penalty is 1 cycle.
//  - JNC taken iff cflag==0, sampled in the execute cycle. cflag reflects the previously executed instruction.
//    BUBBLE cycles must not alter cflag (ALU-side requirement on BUBBLE).
//  - Not-taken JNC: normal sequential flow, no bubble.
//  - Control opcodes are still driven on D_BUS; the ALU must treat them as register no-ops.
//  - HLT executes: state<=HALT, halted=1 from the next cycle; PC/IR frozen; D_BUS=BUBBLE.
//  - hold=1: PC, IR, ir_valid, state unchanged; D_BUS=BUBBLE; no jump resolved.
//    On release, the held instruction executes exactly once.
//  - hold and taken jump in the same cycle: hold wins; jump resolves after release.
//  - Reset mid-RUN or in HALT: immediate return to reset values; in-flight instruction discarded.
// CONFIGURATION
//  SUBROUTINE_EN defined:
//   - Adds a 4-entry return stack of 4-bit entries plus a 3-bit depth counter.
//   - CALL: push PC (already = call address+1), jump to IR[3:0], flush as JMP.
//   - RET: pop into PC, flush as JMP.
//   - CALL with depth 4, or RET with depth 0: no push/pop, stack_err<=1 (sticky), state<=HALT.
//   - Reset clears depth and stack_err.
//  SUBROUTINE_EN undefined:
//   - CALL/RET opcodes are ordinary ALU instructions (no sequencer action).
//   - stack_err tied 0; no stack storage.
// TESTING
//  1. Reset, run=1 1 cycle, ROM[0..2]=8'h31,8'h32,8'h33 -> D_BUS BUBBLE,BUBBLE,31,32,33; rom_addr 0,1,2,3.
//  2. ROM[3]=8'hF0 -> D_BUS 0xF0 then BUBBLE then ROM[0]; PC wraps 15->0 on straight-line ROM.
//  3. JNC 8'hE7 at cflag=1 -> next D_BUS = ROM[next]; at cflag=0 -> BUBBLE then ROM[7].
//  4. hold=1 3 cycles while IR=8'h52 -> D_BUS BUBBLE x3; PC stable; after release 52 appears once.
//  5. HLT 8'hD0 -> halted=1 next cycle, D_BUS=BUBBLE forever, run toggles ignored; reset -> IDLE, halted=0.
//  6. SUBROUTINE_EN: CALL 8'hC8 at addr 2, RET at 8 -> execution resumes at addr 3;
//     5 nested CALLs -> stack_err=1, halted=1.

Source files
------------

// File: rtl/pipe_sequencer_if.sv
// Sequencer-side bundle: ROM fetch port, D_BUS, control and status.
// master = sequencer, slave = datapath/ROM/environment.
interface pipe_sequencer_if;
    logic       run;
    logic       hold;
    logic [7:0] rom_data;
    logic       cflag;
    logic [3:0] rom_addr;
    logic [7:0] D_BUS;
    logic       halted;
    logic       stack_err;

    modport master (
        input  run, hold, rom_data, cflag,
        output rom_addr, D_BUS, halted, stack_err
    );

    modport slave (
        output run, hold, rom_data, cflag,
        input  rom_addr, D_BUS, halted, stack_err
    );
endinterface

// File: rtl/pipe_sequencer.sv
// Two-stage fetch/execute sequencer for the 4-bit CPU datapath.
// Optional return stack (CALL/RET, stack_err) enabled by `define SUBROUTINE_EN.
module pipe_sequencer #(
    parameter logic [3:0] OP_JMP = 4'hF,
    parameter logic [3:0] OP_JNC = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hD,
    parameter logic [7:0] BUBBLE = 8'h00
) (
    input logic              clock,
    input logic              reset,
    pipe_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       ir_valid_q, ir_valid_d;

    logic [3:0] op;
    logic       is_jmp;
    logic       is_hlt;

    assign op     = ir_q[7:4];
    assign is_jmp = (op == OP_JMP) || ((op == OP_JNC) && !bus.cflag);
    assign is_hlt = (op == OP_HLT);

`ifdef SUBROUTINE_EN
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hB;

    logic [3:0] stk_q [4];
    logic [3:0] stk_d [4];
    logic [2:0] depth_q, depth_d;
    logic       err_q, err_d;
    logic       is_call;
    logic       is_ret;

    assign is_call = (op == OP_CALL);
    assign is_ret  = (op == OP_RET);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
`ifdef SUBROUTINE_EN
        stk_d      = stk_q;
        depth_d    = depth_q;
        err_d      = err_q;
`endif
        if (!bus.hold) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.run) state_d = RUN;
                end
                RUN: begin
                    ir_d       = bus.rom_data;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 4'd1;
                    if (ir_valid_q) begin
                        unique case (1'b1)
                            is_jmp: begin
                                pc_d       = ir_q[3:0];
                                ir_valid_d = 1'b0;
                            end
                            is_hlt: begin
                                state_d    = HALT;
                                pc_d       = pc_q;
                                ir_d       = ir_q;
                                ir_valid_d = ir_valid_q;
                            end
`ifdef SUBROUTINE_EN
                            is_call: begin
                                if (depth_q == 3'd4) begin
                                    err_d      = 1'b1;
                                    state_d    = HALT;
                                    pc_d       = pc_q;
                                    ir_d       = ir_q;
                                    ir_valid_d = ir_valid_q;
                                end else begin
                                    stk_d[depth_q[1:0]] = pc_q;
                                    depth_d    = depth_q + 3'd1;
                                    pc_d       = ir_q[3:0];
                                    ir_valid_d = 1'b0;
                                end
                            end
                            is_ret: begin
                                if (depth_q == 3'd0) begin
                                    err_d      = 1'b1;
                                    state_d    = HALT;
                                    pc_d       = pc_q;
                                    ir_d       = ir_q;
                                    ir_valid_d = ir_valid_q;
                                end else begin
                                    pc_d       = stk_q[depth_q[1:0] - 2'd1];
                                    depth_d    = depth_q - 3'd1;
                                    ir_valid_d = 1'b0;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= 4'd0;
            ir_q       <= BUBBLE;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

`ifdef SUBROUTINE_EN
    // Stack contents need no reset; depth alone defines what is valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
        stk_q <= stk_d;
    end

    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.rom_addr = pc_q;
    assign bus.halted   = (state_q == HALT);
    assign bus.D_BUS    = (state_q == RUN && ir_valid_q && !bus.hold)
                          ? ir_q : BUBBLE;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: fetch latency, jumps, hold, halt,
// and (with SUBROUTINE_EN) call/return and stack overflow.
module tb_pipe_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rom [16];

    int n_chk  = 0;
    int n_fail = 0;

    pipe_sequencer_if sif ();

    pipe_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif.master)
    );

    always #5 clock = ~clock;

    assign sif.rom_data = rom[sif.rom_addr];

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        sif.run  = 1'b0;
        sif.hold = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // run for one cycle; returns in the cycle after run was sampled
    task automatic start();
        sif.run = 1'b1;
        check("bus_at_run", sif.D_BUS, 8'h00);
        tick();
        sif.run = 1'b0;
        check("bus_n1", sif.D_BUS, 8'h00);
        check("addr_n1", {4'h0, sif.rom_addr}, 8'h00);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a;
        int guard;
        sif.run   = 1'b0;
        sif.hold  = 1'b0;
        sif.cflag = 1'b1;

        // sequential fetch then JMP 0
        clear_rom();
        rom[0] = 8'h31; rom[1] = 8'h32; rom[2] = 8'h33; rom[3] = 8'hF0;
        do_reset();
        check("rst_bus", sif.D_BUS, 8'h00);
        check("rst_addr", {4'h0, sif.rom_addr}, 8'h00);
        check("rst_halted", {7'h0, sif.halted}, 8'h00);
        check("rst_serr", {7'h0, sif.stack_err}, 8'h00);
        start();
        check("seq0", sif.D_BUS, 8'h31);
        check("seq0_addr", {4'h0, sif.rom_addr}, 8'h01);
        tick();
        check("seq1", sif.D_BUS, 8'h32);
        check("seq1_addr", {4'h0, sif.rom_addr}, 8'h02);
        tick();
        check("seq2", sif.D_BUS, 8'h33);
        check("seq2_addr", {4'h0, sif.rom_addr}, 8'h03);
        tick();
        check("jmp", sif.D_BUS, 8'hF0);
        tick();
        check("jmp_bubble", sif.D_BUS, 8'h00);
        check("jmp_addr", {4'h0, sif.rom_addr}, 8'h00);
        tick();
        check("jmp_tgt", sif.D_BUS, 8'h31);

        // straight-line wrap 15 -> 0
        for (int i = 0; i < 16; i++) rom[i] = 8'h20 + 8'(i);
        do_reset();
        start();
        for (int k = 0; k < 20; k++) begin
            a = 4'(k + 1);
            check("wrap_bus", sif.D_BUS, 8'h20 + 8'(k % 16));
            check("wrap_addr", {4'h0, sif.rom_addr}, {4'h0, a});
            tick();
        end

        // JNC not taken then taken
        clear_rom();
        rom[0] = 8'hE7; rom[1] = 8'h41; rom[2] = 8'hE7; rom[3] = 8'h42;
        rom[7] = 8'h47; rom[8] = 8'h48;
        do_reset();
        sif.cflag = 1'b1;
        start();
        check("jnc_nt", sif.D_BUS, 8'hE7);
        tick();
        check("jnc_nt_next", sif.D_BUS, 8'h41);
        tick();
        check("jnc_t", sif.D_BUS, 8'hE7);
        sif.cflag = 1'b0;
        tick();
        check("jnc_bubble", sif.D_BUS, 8'h00);
        tick();
        check("jnc_tgt", sif.D_BUS, 8'h47);
        tick();
        check("jnc_tgt1", sif.D_BUS, 8'h48);
        sif.cflag = 1'b1;

        // hold, then hold colliding with a taken jump
        clear_rom();
        rom[0] = 8'h51; rom[1] = 8'h52; rom[2] = 8'h53;
        rom[3] = 8'h54; rom[4] = 8'hF9; rom[9] = 8'h59;
        do_reset();
        start();
        check("hold_pre", sif.D_BUS, 8'h51);
        tick();
        sif.hold = 1'b1;
        #1;
        check("hold0", sif.D_BUS, 8'h00);
        check("hold0_addr", {4'h0, sif.rom_addr}, 8'h02);
        tick();
        check("hold1", sif.D_BUS, 8'h00);
        check("hold1_addr", {4'h0, sif.rom_addr}, 8'h02);
        tick();
        check("hold2", sif.D_BUS, 8'h00);
        check("hold2_addr", {4'h0, sif.rom_addr}, 8'h02);
        tick();
        sif.hold = 1'b0;
        #1;
        check("hold_rel", sif.D_BUS, 8'h52);
        tick();
        check("hold_after", sif.D_BUS, 8'h53);
        tick();
        check("hold_after1", sif.D_BUS, 8'h54);
        tick();
        sif.hold = 1'b1;
        #1;
        check("hjmp_held", sif.D_BUS, 8'h00);
        tick();
        check("hjmp_addr", {4'h0, sif.rom_addr}, 8'h05);
        sif.hold = 1'b0;
        #1;
        check("hjmp_rel", sif.D_BUS, 8'hF9);
        tick();
        check("hjmp_bubble", sif.D_BUS, 8'h00);
        tick();
        check("hjmp_tgt", sif.D_BUS, 8'h59);

        // HLT
        clear_rom();
        rom[0] = 8'h61; rom[1] = 8'hD0; rom[2] = 8'h62;
        do_reset();
        start();
        check("hlt_pre", sif.D_BUS, 8'h61);
        tick();
        check("hlt_exec", sif.D_BUS, 8'hD0);
        check("hlt_exec_h", {7'h0, sif.halted}, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("halt_h", {7'h0, sif.halted}, 8'h01);
            check("halt_bus", sif.D_BUS, 8'h00);
            check("halt_addr", {4'h0, sif.rom_addr}, 8'h02);
            sif.run = ~sif.run;
            tick();
        end
        do_reset();
        check("hlt_rst_h", {7'h0, sif.halted}, 8'h00);
        check("hlt_rst_addr", {4'h0, sif.rom_addr}, 8'h00);
        tick();
        tick();
        check("idle_bus", sif.D_BUS, 8'h00);
        check("idle_addr", {4'h0, sif.rom_addr}, 8'h00);

`ifdef SUBROUTINE_EN
        // CALL at 2, RET at 8
        clear_rom();
        rom[0] = 8'h70; rom[1] = 8'h71; rom[2] = 8'hC8;
        rom[3] = 8'h73; rom[8] = 8'hB0;
        do_reset();
        start();
        check("call_pre", sif.D_BUS, 8'h70);
        tick();
        check("call_pre1", sif.D_BUS, 8'h71);
        tick();
        check("call", sif.D_BUS, 8'hC8);
        tick();
        check("call_bubble", sif.D_BUS, 8'h00);
        check("call_addr", {4'h0, sif.rom_addr}, 8'h08);
        tick();
        check("ret", sif.D_BUS, 8'hB0);
        tick();
        check("ret_bubble", sif.D_BUS, 8'h00);
        tick();
        check("ret_tgt", sif.D_BUS, 8'h73);
        check("ret_serr", {7'h0, sif.stack_err}, 8'h00);

        // five nested CALLs overflow the stack
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = 8'hC1 + 8'(i);
        do_reset();
        start();
        guard = 0;
        while (!sif.halted && guard < 30) begin
            tick();
            guard++;
        end
        check("ovf_halted", {7'h0, sif.halted}, 8'h01);
        check("ovf_serr", {7'h0, sif.stack_err}, 8'h01);
        check("ovf_bus", sif.D_BUS, 8'h00);
        do_reset();
        check("ovf_rst_serr", {7'h0, sif.stack_err}, 8'h00);
`else
        // CALL/RET are plain instructions without the stack
        clear_rom();
        rom[0] = 8'hC8; rom[1] = 8'hB0; rom[2] = 8'h73;
        do_reset();
        start();
        check("nocall", sif.D_BUS, 8'hC8);
        tick();
        check("noret", sif.D_BUS, 8'hB0);
        tick();
        check("nocall_seq", sif.D_BUS, 8'h73);
        check("noserr", {7'h0, sif.stack_err}, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
